// File: rtl/scan_alu_pkg.sv
// Shared constants and field-position helpers for the scan-controlled ALU unit.
package scan_alu_pkg;

  localparam logic [1:0] OP_INIT_MEM = 2'b00;
  localparam logic [1:0] OP_ARITH    = 2'b01;
  localparam logic [1:0] OP_LOGIC    = 2'b10;
  localparam logic [1:0] OP_BUFFER   = 2'b11;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  localparam logic MODE_AND = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  // Opcode occupies the two MSBs of the instruction.
  function automatic int unsigned op_lsb(int unsigned ir_w);
    return ir_w - 2;
  endfunction

  function automatic int unsigned mode_pos(int unsigned ir_w);
    return ir_w - 3;
  endfunction

  // INIT_MEM address sits directly above the data field.
  function automatic int unsigned init_addr_lsb(int unsigned data_w);
    return data_w;
  endfunction

  // Operand A address sits directly above operand B address.
  function automatic int unsigned addr_a_lsb(int unsigned addr_w);
    return addr_w;
  endfunction

  // Smallest instruction width that holds every field layout plus opcode.
  function automatic int unsigned ir_w_min(int unsigned addr_w, int unsigned data_w,
                                           int unsigned res_w);
    int unsigned m;
    m = addr_w + data_w;
    if (1 + 2 * addr_w > m) m = 1 + 2 * addr_w;
    if (res_w > m) m = res_w;
    return 2 + m;
  endfunction

endpackage

// File: rtl/scan_alu_unit_chain.sv
// Shift chain, shadow register and capture path for scan_alu_unit.
// Optional SHIFT_COUNT_CHECK_EN: only accept updates after exactly IR_W shifts.
module scan_chain_reg
  import scan_alu_pkg::*;
#(
  parameter int unsigned IR_W  = 8,
  parameter int unsigned RES_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             shift_en,
  input  logic             update_en,
  input  logic             capture_en,
  input  logic [RES_W-1:0] capture_data,
  output logic             data_out,
  output logic [IR_W-1:0]  shadow,
  output logic             update_ok_c
);

  logic [IR_W-1:0] shift_reg;
  logic [IR_W-1:0] shadow_reg;

  assign data_out = shift_reg[IR_W-1];
  assign shadow   = shadow_reg;

`ifdef SHIFT_COUNT_CHECK_EN
  localparam int unsigned CNT_W   = $clog2(IR_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IR_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(IR_W + 1);

  logic [CNT_W-1:0] shift_cnt;

  assign update_ok_c = (shift_cnt == CNT_FULL);

  // Shifts since last legal update or capture, saturating one past full.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_cnt <= '0;
    end else if (shift_en) begin
      if (shift_cnt != CNT_SAT) shift_cnt <= shift_cnt + CNT_W'(1);
    end else if ((update_en && update_ok_c) || capture_en) begin
      shift_cnt <= '0;
    end
  end
`else
  assign update_ok_c = 1'b1;
`endif

  // Strobes arrive already priority-resolved, so at most one is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg  <= '0;
      shadow_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[IR_W-2:0], data_in};
    end else if (update_en) begin
      if (update_ok_c) shadow_reg <= shift_reg;
    end else if (capture_en) begin
      shift_reg <= IR_W'(capture_data);
    end
  end

endmodule

// File: rtl/scan_alu_unit.sv
// Serially programmed compute unit: register file, ALU, result and protocol-error flags.
// Optional SHIFT_COUNT_CHECK_EN enables the shift-count check on update.
module scan_alu_unit
  import scan_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned RES_W  = DATA_W + 1,
  parameter int unsigned IR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             shift,
  input  logic             update,
  input  logic             run,
  input  logic             capture,
  output logic             data_out,
  output logic [RES_W-1:0] z,
  output logic             z_valid,
  output logic             cmd_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (IR_W < ir_w_min(ADDR_W, DATA_W, RES_W)) begin : g_ir_w_check
    $error("scan_alu_unit: IR_W too small for the configured field widths");
  end

  logic shift_win, update_win, run_win, capture_win, multi_strobe;
  logic [IR_W-1:0] shadow;
  logic update_ok_c;

  // Priority shift > update > run > capture; any overlap is a protocol error.
  assign shift_win    = shift;
  assign update_win   = update & ~shift;
  assign run_win      = run & ~shift & ~update;
  assign capture_win  = capture & ~shift & ~update & ~run;
  assign multi_strobe = (shift & (update | run | capture)) | (update & (run | capture))
                      | (run & capture);

  scan_chain_reg #(
    .IR_W  (IR_W),
    .RES_W (RES_W)
  ) u_chain (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .shift_en     (shift_win),
    .update_en    (update_win),
    .capture_en   (capture_win),
    .capture_data (z),
    .data_out     (data_out),
    .shadow       (shadow),
    .update_ok_c  (update_ok_c)
  );

  logic [1:0]        op;
  logic              mode;
  logic [ADDR_W-1:0] init_addr, addr_a, addr_b;
  logic [DATA_W-1:0] init_data, opnd_a, opnd_b;
  logic [RES_W-1:0]  payload, alu_res;
  logic [DATA_W-1:0] mem [DEPTH];

  assign op        = shadow[op_lsb(IR_W) +: 2];
  assign mode      = shadow[mode_pos(IR_W)];
  assign init_addr = shadow[init_addr_lsb(DATA_W) +: ADDR_W];
  assign init_data = shadow[DATA_W-1:0];
  assign addr_a    = shadow[addr_a_lsb(ADDR_W) +: ADDR_W];
  assign addr_b    = shadow[ADDR_W-1:0];
  assign payload   = shadow[RES_W-1:0];
  assign opnd_a    = mem[addr_a];
  assign opnd_b    = mem[addr_b];

  // Result width carries the add carry-out or the subtract borrow in its MSB.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ARITH: begin
        if (mode == MODE_SUB) alu_res = RES_W'(opnd_a) - RES_W'(opnd_b);
        else                  alu_res = RES_W'(opnd_a) + RES_W'(opnd_b);
      end
      OP_LOGIC: begin
        if (mode == MODE_OR) alu_res = RES_W'(opnd_a | opnd_b);
        else                 alu_res = RES_W'(opnd_a & opnd_b);
      end
      OP_BUFFER: alu_res = payload;
      default:   alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      z       <= '0;
      z_valid <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      z_valid <= run_win;
      cmd_err <= cmd_err | multi_strobe | (update_win & ~update_ok_c);
      if (run_win) begin
        if (op == OP_INIT_MEM) mem[init_addr] <= init_data;
        else                   z <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_scan_alu_unit.sv
// Directed self-checking bench for scan_alu_unit (default parameters).
module tb_scan_alu_unit;

  localparam int unsigned IR_W  = 8;
  localparam int unsigned RES_W = 5;

  logic             clk = 1'b0;
  logic             reset, data_in, shift, update, run, capture;
  logic             data_out, z_valid, cmd_err;
  logic [RES_W-1:0] z;

  int checks = 0;
  int errors = 0;

  scan_alu_unit dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .shift    (shift),
    .update   (update),
    .run      (run),
    .capture  (capture),
    .data_out (data_out),
    .z        (z),
    .z_valid  (z_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [IR_W-1:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = w[i];
      shift   = 1'b1;
      tick();
    end
    shift   = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic pulse_update();
    update = 1'b1; tick(); update = 1'b0;
  endtask

  task automatic pulse_capture();
    capture = 1'b1; tick(); capture = 1'b0;
  endtask

  // Load and execute one instruction; leaves sampling just after the run edge.
  task automatic exec(input logic [IR_W-1:0] w);
    shift_bits(w, IR_W);
    pulse_update();
    run = 1'b1; tick(); run = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({z, z_valid, cmd_err, data_out} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got z=%h zv=%b err=%b do=%b, want all 0", z, z_valid, cmd_err, data_out);
    end
  endtask

  task automatic test_init_add();
    exec(8'h1F);
    exec(8'h23);
    exec(8'h46);
    checks++;
    if (z !== 5'h12 || z_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_result: got z=%h zv=%b, want z=12 zv=1", z, z_valid);
    end
    tick();
    checks++;
    if (z_valid !== 1'b0 || z !== 5'h12) begin
      errors++;
      $display("FAIL add_pulse: got z=%h zv=%b, want z=12 zv=0", z, z_valid);
    end
  endtask

  task automatic test_sub_borrow();
    exec(8'h03);
    exec(8'h35);
    exec(8'h63);
    checks++;
    if (z !== 5'h1E) begin
      errors++;
      $display("FAIL sub_borrow: got z=%h, want 1e", z);
    end
  endtask

  task automatic test_logic_capture();
    logic [7:0] exp_seq;
    exec(8'h1A);
    exec(8'h25);
    exec(8'h86);
    checks++;
    if (z !== 5'h00) begin
      errors++;
      $display("FAIL logic_and: got z=%h, want 00", z);
    end
    exec(8'hA6);
    checks++;
    if (z !== 5'h0F) begin
      errors++;
      $display("FAIL logic_or: got z=%h, want 0f", z);
    end
    pulse_capture();
    exp_seq = 8'b0000_1111;
    for (int i = 7; i >= 0; i--) begin
      checks++;
      if (data_out !== exp_seq[i]) begin
        errors++;
        $display("FAIL capture_bit%0d: got data_out=%b, want %b", 7 - i, data_out, exp_seq[i]);
      end
      shift = 1'b1; tick(); shift = 1'b0;
    end
  endtask

  task automatic test_buffer_multi();
    exec(8'hD5);
    checks++;
    if (z !== 5'h15) begin
      errors++;
      $display("FAIL buffer: got z=%h, want 15", z);
    end
    data_in = 1'b1; shift = 1'b1; run = 1'b1;
    tick();
    shift = 1'b0; run = 1'b0; data_in = 1'b0;
    checks++;
    if (z_valid !== 1'b0 || z !== 5'h15 || cmd_err !== 1'b1 || dut.u_chain.shift_reg !== 8'hAB) begin
      errors++;
      $display("FAIL shift_run_conflict: got zv=%b z=%h err=%b sr=%h, want 0 15 1 ab",
               z_valid, z, cmd_err, dut.u_chain.shift_reg);
    end
    tick(); tick(); tick();
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got cmd_err=%b, want 1", cmd_err);
    end
  endtask

  task automatic test_back_to_back();
    run = 1'b1;
    tick();
    checks++;
    if (z_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got zv=%b, want 1", z_valid);
    end
    tick();
    run = 1'b0;
    checks++;
    if (z_valid !== 1'b1 || z !== 5'h15) begin
      errors++;
      $display("FAIL b2b_second: got zv=%b z=%h, want 1 15", z_valid, z);
    end
    tick();
    checks++;
    if (z_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got zv=%b, want 0", z_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    shift_bits(8'hFF, 3);
    reset = 1'b1; shift = 1'b1; run = 1'b1; data_in = 1'b1;
    tick();
    reset = 1'b0; shift = 1'b0; run = 1'b0; data_in = 1'b0;
    checks++;
    if (dut.u_chain.shift_reg !== 8'h00 || dut.u_chain.shadow_reg !== 8'h00 ||
        z !== 5'h00 || z_valid !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift_reset: got sr=%h sh=%h z=%h zv=%b err=%b, want all 0",
               dut.u_chain.shift_reg, dut.u_chain.shadow_reg, z, z_valid, cmd_err);
    end
    run = 1'b1; tick(); run = 1'b0;
    checks++;
    if (z !== 5'h00 || z_valid !== 1'b1) begin
      errors++;
      $display("FAIL run_after_reset: got z=%h zv=%b, want 00 1", z, z_valid);
    end
    exec(8'h4F);
    checks++;
    if (z !== 5'h00) begin
      errors++;
      $display("FAIL mem_cleared: got z=%h, want 00", z);
    end
  endtask

  task automatic test_shift_count();
    apply_reset();
    shift_bits(8'hD5, 7);
    pulse_update();
`ifdef SHIFT_COUNT_CHECK_EN
    checks++;
    if (dut.u_chain.shadow_reg !== 8'h00 || cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL short_update: got sh=%h err=%b, want 00 1", dut.u_chain.shadow_reg, cmd_err);
    end
`else
    checks++;
    if (dut.u_chain.shadow_reg !== 8'h55 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL short_update: got sh=%h err=%b, want 55 0", dut.u_chain.shadow_reg, cmd_err);
    end
`endif
    apply_reset();
    shift_bits(8'hD5, 8);
    pulse_update();
    checks++;
    if (dut.u_chain.shadow_reg !== 8'hD5 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL full_update: got sh=%h err=%b, want d5 0", dut.u_chain.shadow_reg, cmd_err);
    end
  endtask

  initial begin
    reset = 1'b1; data_in = 1'b0; shift = 1'b0; update = 1'b0; run = 1'b0; capture = 1'b0;
    test_reset();
    test_init_add();
    test_sub_borrow();
    test_logic_capture();
    test_buffer_multi();
    test_back_to_back();
    test_reset_mid_shift();
    test_shift_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
